// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serializes the two memory-stage slots onto one
// single-ported, variable-latency data memory, stalling until both finish.
module dmem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s1_memread,
  input  logic              s1_memwrite,
  input  logic [DATA_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic              s2_memread,
  input  logic              s2_memwrite,
  input  logic [DATA_W-1:0] s2_addr,
  input  logic [DATA_W-1:0] s2_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [DATA_W-1:0] s2_rdata,
  output logic              mem_stall,
  output logic              bus_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    SERVE1,
    SERVE2,
    RELEASE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              c2_v;
  logic              c2_we;
  logic [DATA_W-1:0] c2_addr;
  logic [DATA_W-1:0] c2_wdata;

  logic req1;
  logic req2;
  logic serving;
  logic expired;
  logic done;

  assign req1    = s1_memread | s1_memwrite;
  assign req2    = s2_memread | s2_memwrite;
  assign serving = (state == SERVE1) | (state == SERVE2);

  // The last permitted wait cycle ends the access as abandoned.
  assign expired = TO_EN & ~mem_ready & (cnt == CNT_LAST);
  assign done    = mem_ready | expired;

  // Stall is forced low while reset is held so the pipeline is released.
  always_comb begin
    mem_stall = reset & (serving | ((state == IDLE) & (req1 | req2)));
  end

  // Sequencer: captures both slots, issues slot 1 then slot 2, then releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      c2_v      <= 1'b0;
      c2_we     <= 1'b0;
      c2_addr   <= '0;
      c2_wdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_rdata  <= '0;
      s2_rdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req1 | req2) begin
            c2_v     <= req2;
            c2_we    <= s2_memwrite;
            c2_addr  <= s2_addr;
            c2_wdata <= s2_wdata;
            cnt      <= '0;
            mem_req  <= 1'b1;
            if (req1) begin
              mem_we    <= s1_memwrite;
              mem_addr  <= s1_addr;
              mem_wdata <= s1_wdata;
              state     <= SERVE1;
            end else begin
              mem_we    <= s2_memwrite;
              mem_addr  <= s2_addr;
              mem_wdata <= s2_wdata;
              state     <= SERVE2;
            end
          end
        end
        SERVE1, SERVE2: begin
          if (done) begin
            cnt <= '0;
            if (expired) begin
              bus_err <= 1'b1;
            end
            if (!mem_we) begin
              if (state == SERVE1) begin
                s1_rdata <= expired ? '0 : mem_rdata;
              end else begin
                s2_rdata <= expired ? '0 : mem_rdata;
              end
            end
            if ((state == SERVE1) && c2_v) begin
              mem_we    <= c2_we;
              mem_addr  <= c2_addr;
              mem_wdata <= c2_wdata;
              state     <= SERVE2;
            end else begin
              mem_req <= 1'b0;
              state   <= RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the slot sequencer against
// a small behavioural memory with programmable wait states.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        s1_memread;
  logic        s1_memwrite;
  logic [31:0] s1_addr;
  logic [31:0] s1_wdata;
  logic        s2_memread;
  logic        s2_memwrite;
  logic [31:0] s2_addr;
  logic [31:0] s2_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] s1_rdata;
  logic [31:0] s2_rdata;
  logic        mem_stall;
  logic        bus_err;

  int pass;
  int total;
  int fails;

  int waits;
  int wc;
  bit hang;
  logic [31:0] mem [logic [31:0]];

  dmem_port_arbiter #(
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s1_memread (s1_memread),
    .s1_memwrite(s1_memwrite),
    .s1_addr    (s1_addr),
    .s1_wdata   (s1_wdata),
    .s2_memread (s2_memread),
    .s2_memwrite(s2_memwrite),
    .s2_addr    (s2_addr),
    .s2_wdata   (s2_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .s1_rdata   (s1_rdata),
    .s2_rdata   (s2_rdata),
    .mem_stall  (mem_stall),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Memory answers on the falling edge; garbage on rdata when not a read.
  always @(negedge clk) begin
    if (mem_req && !hang) begin
      if (wc == waits) begin
        mem_ready = 1'b1;
        wc = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          mem_rdata = 32'h0BAD_0BAD;
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_0000;
        wc++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_0001;
      wc = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    s1_memread  = 0;
    s1_memwrite = 0;
    s2_memread  = 0;
    s2_memwrite = 0;
  endtask

  initial begin
    pass = 0;
    total = 0;
    fails = 0;
    clk = 0;
    reset = 0;
    waits = 0;
    wc = 0;
    hang = 0;
    mem_ready = 0;
    mem_rdata = 0;
    drop();
    s1_addr = 0;
    s1_wdata = 0;
    s2_addr = 0;
    s2_wdata = 0;
    mem[32'h10] = 32'hCAFE_F00D;
    mem[32'h20] = 32'h1111_1111;
    mem[32'h24] = 32'h2222_2222;
    mem[32'h40] = 32'hDEAD_BEEF;
    mem[32'h50] = 32'h3333_3333;
    mem[32'h60] = 32'h4444_4444;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_stall", {31'b0, mem_stall}, 0);
    chk("rst_err", {31'b0, bus_err}, 0);
    chk("rst_rd1", s1_rdata, 0);
    chk("rst_rd2", s2_rdata, 0);
    reset = 1;
    cyc();

    // single load, 0 waits
    s1_memread = 1;
    s1_addr = 32'h10;
    #1;
    chk("sl_stall_idle", {31'b0, mem_stall}, 1);
    chk("sl_req_idle", {31'b0, mem_req}, 0);
    cyc();
    chk("sl_req", {31'b0, mem_req}, 1);
    chk("sl_we", {31'b0, mem_we}, 0);
    chk("sl_addr", mem_addr, 32'h10);
    chk("sl_stall", {31'b0, mem_stall}, 1);
    cyc();
    chk("sl_rel_stall", {31'b0, mem_stall}, 0);
    chk("sl_rel_req", {31'b0, mem_req}, 0);
    chk("sl_rd1", s1_rdata, 32'hCAFE_F00D);
    chk("sl_rd2", s2_rdata, 0);
    drop();
    cyc();
    chk("sl_idle_stall", {31'b0, mem_stall}, 0);
    chk("sl_hold1", s1_rdata, 32'hCAFE_F00D);

    // dual load, 0 waits
    s1_memread = 1;
    s1_addr = 32'h20;
    s2_memread = 1;
    s2_addr = 32'h24;
    #1;
    chk("dl_stall_idle", {31'b0, mem_stall}, 1);
    cyc();
    chk("dl_req1", {31'b0, mem_req}, 1);
    chk("dl_addr1", mem_addr, 32'h20);
    chk("dl_stall1", {31'b0, mem_stall}, 1);
    cyc();
    chk("dl_req2", {31'b0, mem_req}, 1);
    chk("dl_addr2", mem_addr, 32'h24);
    chk("dl_stall2", {31'b0, mem_stall}, 1);
    chk("dl_rd1", s1_rdata, 32'h1111_1111);
    cyc();
    chk("dl_rel_stall", {31'b0, mem_stall}, 0);
    chk("dl_rel_req", {31'b0, mem_req}, 0);
    chk("dl_rd2", s2_rdata, 32'h2222_2222);
    drop();
    cyc();
    chk("dl_hold1", s1_rdata, 32'h1111_1111);
    chk("dl_hold2", s2_rdata, 32'h2222_2222);

    // slot 1 store then slot 2 load, same address
    s1_memwrite = 1;
    s1_addr = 32'h40;
    s1_wdata = 32'hA5A5_A5A5;
    s2_memread = 1;
    s2_addr = 32'h40;
    #1;
    chk("sw_stall_idle", {31'b0, mem_stall}, 1);
    cyc();
    chk("sw_we1", {31'b0, mem_we}, 1);
    chk("sw_addr1", mem_addr, 32'h40);
    chk("sw_wdata1", mem_wdata, 32'hA5A5_A5A5);
    cyc();
    chk("sw_req2", {31'b0, mem_req}, 1);
    chk("sw_we2", {31'b0, mem_we}, 0);
    chk("sw_addr2", mem_addr, 32'h40);
    cyc();
    chk("sw_stall_rel", {31'b0, mem_stall}, 0);
    chk("sw_rd2", s2_rdata, 32'hA5A5_A5A5);
    chk("sw_rd1_kept", s1_rdata, 32'h1111_1111);
    drop();
    cyc();

    // slot 2 only, 3 wait states
    waits = 3;
    s2_memread = 1;
    s2_addr = 32'h50;
    #1;
    chk("ws_stall_idle", {31'b0, mem_stall}, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("ws_req_%0d", i), {31'b0, mem_req}, 1);
      chk($sformatf("ws_addr_%0d", i), mem_addr, 32'h50);
      chk($sformatf("ws_stall_%0d", i), {31'b0, mem_stall}, 1);
    end
    cyc();
    chk("ws_rel_stall", {31'b0, mem_stall}, 0);
    chk("ws_rd2", s2_rdata, 32'h3333_3333);
    chk("ws_rd1_kept", s1_rdata, 32'h1111_1111);
    drop();
    waits = 0;
    cyc();

    // timeout: memory never answers, TIMEOUT = 4
    hang = 1;
    s1_memread = 1;
    s1_addr = 32'h60;
    #1;
    chk("to_stall_idle", {31'b0, mem_stall}, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("to_req_%0d", i), {31'b0, mem_req}, 1);
      chk($sformatf("to_err_%0d", i), {31'b0, bus_err}, 0);
    end
    cyc();
    chk("to_err", {31'b0, bus_err}, 1);
    chk("to_rd1", s1_rdata, 0);
    chk("to_req_rel", {31'b0, mem_req}, 0);
    chk("to_stall_rel", {31'b0, mem_stall}, 0);
    drop();
    hang = 0;
    cyc();
    chk("to_err_sticky", {31'b0, bus_err}, 1);
    chk("to_idle_stall", {31'b0, mem_stall}, 0);

    // reset in the middle of a slot 2 wait
    hang = 1;
    s2_memread = 1;
    s2_addr = 32'h24;
    cyc();
    cyc();
    chk("rs_req_pre", {31'b0, mem_req}, 1);
    reset = 0;
    #1;
    chk("rs_req", {31'b0, mem_req}, 0);
    chk("rs_stall", {31'b0, mem_stall}, 0);
    chk("rs_err", {31'b0, bus_err}, 0);
    chk("rs_rd1", s1_rdata, 0);
    chk("rs_rd2", s2_rdata, 0);
    @(posedge clk);
    #1;
    reset = 1;
    drop();
    hang = 0;
    cyc();
    s1_memread = 1;
    s1_addr = 32'h10;
    #1;
    chk("rs_new_stall", {31'b0, mem_stall}, 1);
    cyc();
    chk("rs_new_req", {31'b0, mem_req}, 1);
    chk("rs_new_addr", mem_addr, 32'h10);
    cyc();
    chk("rs_new_rd1", s1_rdata, 32'hCAFE_F00D);
    chk("rs_new_stall_rel", {31'b0, mem_stall}, 0);
    drop();
    cyc();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the two memory-stage slots of the dual-issue pipeline onto one single-ported, variable-latency data memory.
- Sits between the EX/MEM latch outputs (slot 1 and slot 2 read/write controls, address, store data) and the data memory.
- Serializes same-cycle accesses in program order (slot 1, then slot 2) and freezes the pipeline with a stall until both are done.
- Returns per-slot load data to the MEM/WB latch.

Parameters:
- DATA_W, 32, width of address, store data and load data.
- TIMEOUT, 255, maximum wait cycles per access before it is abandoned; 0 disables the timeout.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- s1_memread  input  1  slot 1 load request.
- s1_memwrite  input  1  slot 1 store request.
- s1_addr  input  DATA_W  slot 1 byte address.
- s1_wdata  input  DATA_W  slot 1 store data.
- s2_memread  input  1  slot 2 load request.
- s2_memwrite  input  1  slot 2 store request.
- s2_addr  input  DATA_W  slot 2 byte address.
- s2_wdata  input  DATA_W  slot 2 store data.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  DATA_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  input  1  access complete this cycle.
- s1_rdata  output  DATA_W  slot 1 load result.
- s2_rdata  output  DATA_W  slot 2 load result.
- mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- bus_err  output  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All registered outputs 0: mem_req, mem_we, mem_addr, mem_wdata, s1_rdata, s2_rdata, bus_err.
  - Wait counter 0, captured requests cleared.
  - Applies at any point, including mid-access; the abandoned access is not retried.
- Per-slot request: req_n = memread_n | memwrite_n. If both memread and memwrite are set, it is treated as a write.
- States:
  - IDLE: if req1|req2, capture both slots (type, addr, wdata, valid); next SERVE1 if req1, else SERVE2. No request: stay.
  - SERVE1: drive slot 1 access. On mem_ready (or timeout): next SERVE2 if slot 2 captured valid, else RELEASE.
  - SERVE2: drive slot 2 access. On mem_ready (or timeout): next RELEASE.
  - RELEASE: one cycle with stall low so the pipeline advances. Inputs are ignored (they still show the completed requests). Next IDLE.
- mem_stall (combinational):
  - 1 in SERVE1 and SERVE2.
  - 1 in IDLE when req1|req2.
  - 0 otherwise.
- Memory interface:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are asserted on entry to a SERVE state and held constant until mem_ready is sampled 1.
  - mem_req drops on the cycle after completion unless the next SERVE starts; for SERVE1 to SERVE2 it stays high with the new fields.
  - mem_ready while mem_req=0 is ignored.
- Load data:
  - On mem_ready for a read, mem_rdata is registered into the serving slot's rdata.
  - Each rdata holds until that slot's next completed read; stores do not alter rdata.
- Latency with a 0-wait memory (mem_ready=1 on the first request cycle):
  - Single access: stall high for 2 cycles (IDLE-detect, SERVE); rdata valid in RELEASE.
  - Dual access: stall high for 3 cycles.
  - Each memory wait cycle adds 1.
- Ordering: slot 1 always completes before slot 2. A slot 1 store followed by a slot 2 load to the same address returns the new data; two stores to the same address leave the slot 2 value.
- Timeout:
  - The counter resets on SERVE entry and increments each cycle with mem_ready=0.
  - When it reaches TIMEOUT (TIMEOUT≠0), the access completes as abandoned: read data is 0, bus_err is set (sticky until reset), and the FSM advances as if mem_ready=1.
- Counter width: ceil(log2(TIMEOUT+1)), minimum 1.

Test Plan:
- Single load: s1_memread=1, s1_addr=0x10, memory returns 0xCAFEF00D with 0 wait states.
  - mem_req=1, mem_we=0, mem_addr=0x10 for 1 cycle; mem_stall high 2 cycles.
  - s1_rdata=0xCAFEF00D in RELEASE; s2_rdata stays 0.
- Dual load: s1 addr 0x20 returns 0x11111111; s2 addr 0x24 returns 0x22222222.
  - Requests go to 0x20 then 0x24 on consecutive cycles; mem_stall high 3 cycles.
  - Both rdata are correct and held after RELEASE.
- Store then load, same address: s1 store 0xA5A5A5A5 to 0x40; s2 load 0x40 from a behavioural memory.
  - Write is issued first; s2_rdata=0xA5A5A5A5.
- Wait states: slot 2 only, read, mem_ready delayed 3 cycles.
  - mem_req/mem_addr held stable for 4 cycles; stall high 5 cycles; s1_rdata unchanged.
- Timeout: TIMEOUT=4, mem_ready held 0.
  - Access is abandoned after 4 wait cycles; bus_err=1 and stays 1.
  - rdata=0; FSM reaches RELEASE then IDLE.
- Reset mid-SERVE2: reset=0 during a slot 2 wait.
  - Immediately mem_req=0, mem_stall=0, bus_err=0, rdata=0.
  - After reset=1, a new request is accepted normally.
